// File: rtl/move_command_generator_pkg.sv
// Shared constants for the display/offset-handler path: display geometry,
// button direction indices, axis FSM states and default timing values.
package move_command_generator_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int DEF_DEBOUNCE_CYCLES     = 500000;
  localparam int DEF_REPEAT_DELAY_FRAMES = 30;
  localparam int DEF_REPEAT_RATE_FRAMES  = 6;
  localparam int DEF_MAX_STEP            = 8;
  localparam int FRAME_CNT_W             = 8;

  typedef enum logic [1:0] {
    AX_IDLE,
    AX_PENDING,
    AX_HOLD,
    AX_REPEAT
  } axis_state_t;

  // Zero means "smallest move"; anything above the limit saturates.
  function automatic logic [3:0] clamp_step(
    input logic [3:0] raw,
    input int         max_step
  );
    if (raw == 4'd0) return 4'd1;
    if (int'(raw) > max_step) return 4'(max_step);
    return raw;
  endfunction

endpackage

// File: rtl/move_command_generator_button_debouncer.sv
// One push-button: 2-flop synchroniser, stable-count debouncer, press edge.
// Ports: clock, reset (async high), btn_raw in; level (accepted), press out.
import move_command_generator_pkg::*;

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count clocks where the synchronised input disagrees with the
  // accepted level; any agreement (a bounce back) restarts from zero.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/move_command_generator.sv
// Turns raw direction buttons and step switches into frame-synchronous
// one-cycle move pulses with tap, hold-repeat and per-axis conflict cancel.
// Ports: clock, reset (async high), buttons {R,L,D,U}, stepSelect,
//        frameTick in; moveDirection {R,L,D,U} pulses, moveStep out.
import move_command_generator_pkg::*;

module move_command_generator #(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_FRAMES = DEF_REPEAT_DELAY_FRAMES,
  parameter int REPEAT_RATE_FRAMES  = DEF_REPEAT_RATE_FRAMES,
  parameter int MAX_STEP            = DEF_MAX_STEP
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic [3:0] stepSelect,
  input  logic       frameTick,
  output logic [3:0] moveDirection,
  output logic [3:0] moveStep
);

  localparam logic [FRAME_CNT_W-1:0] DELAY_C =
    FRAME_CNT_W'(REPEAT_DELAY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] RATE_C =
    FRAME_CNT_W'(REPEAT_RATE_FRAMES);

  logic [3:0] level;
  logic [3:0] press;
  logic [1:0] axis_pulse [2];

  for (genvar b = 0; b < 4; b++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(buttons[b]),
      .level  (level[b]),
      .press  (press[b])
    );
  end

  // Axis 0 = {Down, Up}, axis 1 = {Right, Left}; lo bit is Up/Left.
  for (genvar ax = 0; ax < 2; ax++) begin : g_axis
    localparam int LO = 2 * ax;
    localparam int HI = 2 * ax + 1;

    axis_state_t            state_q, state_d;
    logic                   dir_q, dir_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]             pulse_q, pulse_d;
    logic                   conflict;
    logic                   held;

    assign conflict = level[LO] & level[HI];
    assign held     = dir_q ? level[HI] : level[LO];

    always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      pulse_d = 2'b00;
      if (conflict) begin
        state_d = AX_IDLE;
      end else begin
        unique case (state_q)
          AX_IDLE: begin
            if (press[LO] ^ press[HI]) begin
              dir_d   = press[HI];
              state_d = AX_PENDING;
            end
          end
          // A tap is committed: release here does not cancel it.
          AX_PENDING: begin
            if (frameTick) begin
              pulse_d = dir_q ? 2'b10 : 2'b01;
              cnt_d   = DELAY_C;
              state_d = AX_HOLD;
            end
          end
          AX_HOLD, AX_REPEAT: begin
            if (!held) begin
              state_d = AX_IDLE;
            end else if (frameTick) begin
              if (cnt_q <= 1) begin
                pulse_d = dir_q ? 2'b10 : 2'b01;
                cnt_d   = RATE_C;
                state_d = AX_REPEAT;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
          end
          default: state_d = AX_IDLE;
        endcase
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= AX_IDLE;
        dir_q   <= 1'b0;
        cnt_q   <= '0;
        pulse_q <= 2'b00;
      end else begin
        state_q <= state_d;
        dir_q   <= dir_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign axis_pulse[ax] = pulse_q;
  end

  assign moveDirection = {axis_pulse[1], axis_pulse[0]};

  logic [3:0] ssync1_q, ssync1_d;
  logic [3:0] ssync2_q, ssync2_d;
  logic [3:0] step_q, step_d;

  // Step only moves on the tick, so it is already stable when the
  // pulse it qualifies appears on the following cycle.
  always_comb begin
    ssync1_d = stepSelect;
    ssync2_d = ssync1_q;
    step_d   = step_q;
    if (frameTick) step_d = clamp_step(ssync2_q, MAX_STEP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ssync1_q <= 4'd0;
      ssync2_q <= 4'd0;
      step_q   <= 4'd1;
    end else begin
      ssync1_q <= ssync1_d;
      ssync2_q <= ssync2_d;
      step_q   <= step_d;
    end
  end

  assign moveStep = step_q;

endmodule

// File: tb/tb_move_command_generator.sv
// Directed bench for move_command_generator with short debounce.
// Scenario tasks check pulses, timing, conflicts, step and reset.
module tb_move_command_generator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'd0;
  logic [3:0] stepSelect = 4'd1;
  logic       frameTick = 1'b0;
  logic [3:0] moveDirection;
  logic [3:0] moveStep;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  int cyc   = 0;
  int last_tick = -10;
  int frame_no  = 0;
  logic [3:0] prev_dir = 4'd0;
  int         pulse_frames [$];
  logic [3:0] pulse_vals   [$];

  move_command_generator #(
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_FRAMES(30),
    .REPEAT_RATE_FRAMES (6),
    .MAX_STEP           (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttons      (buttons),
    .stepSelect   (stepSelect),
    .frameTick    (frameTick),
    .moveDirection(moveDirection),
    .moveStep     (moveStep)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (frameTick) last_tick = cyc;
    if (moveDirection != 4'd0) begin
      pulse_frames.push_back(frame_no);
      pulse_vals.push_back(moveDirection);
      if (cyc != last_tick + 1) begin
        viol++;
        $display("FAIL pulse_timing cyc=%0d tick=%0d", cyc, last_tick);
      end
    end
    if ((moveDirection & prev_dir) != 4'd0) begin
      viol++;
      $display("FAIL pulse_width dir=%b prev=%b", moveDirection, prev_dir);
    end
    if ((moveDirection[0] & moveDirection[1]) ||
        (moveDirection[2] & moveDirection[3])) begin
      viol++;
      $display("FAIL opposite_dirs dir=%b", moveDirection);
    end
    prev_dir = moveDirection;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_frames(input int n, input int len);
    repeat (n) begin
      clk_wait(len - 1);
      frameTick = 1'b1;
      frame_no++;
      clk_wait(1);
      frameTick = 1'b0;
    end
  endtask

  task automatic clear_log();
    pulse_frames.delete();
    pulse_vals.delete();
    frame_no = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_wait(3);
    tests++;
    if (moveDirection !== 4'd0) begin
      fails++;
      $display("FAIL reset_dir got=%b exp=0000", moveDirection);
    end
    tests++;
    if (moveStep !== 4'd1) begin
      fails++;
      $display("FAIL reset_step got=%0d exp=1", moveStep);
    end
    reset = 1'b0;
    clk_wait(2);
  endtask

  task automatic test_tap();
    clear_log();
    for (int i = 0; i < 3; i++) begin
      buttons[0] = 1'b1;
      clk_wait(1);
      buttons[0] = 1'b0;
      clk_wait(1);
    end
    buttons[0] = 1'b1;
    clk_wait(20);
    buttons[0] = 1'b0;
    do_frames(1, 100);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 1) begin
      fails++;
      $display("FAIL tap_count got=%0d exp=1", pulse_vals.size());
    end
    tests++;
    if (pulse_vals.size() < 1 || pulse_vals[0] !== 4'b0001) begin
      fails++;
      $display("FAIL tap_value n=%0d exp=0001", pulse_vals.size());
    end
    do_frames(3, 100);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 1) begin
      fails++;
      $display("FAIL tap_after got=%0d exp=1", pulse_vals.size());
    end
  endtask

  task automatic test_hold_repeat();
    int exp_f [5] = '{1, 31, 37, 43, 49};
    clear_log();
    buttons[3] = 1'b1;
    clk_wait(10);
    do_frames(50, 20);
    buttons[3] = 1'b0;
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 5) begin
      fails++;
      $display("FAIL hold_count got=%0d exp=5", pulse_vals.size());
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (pulse_vals.size() <= i ||
          pulse_frames[i] != exp_f[i] ||
          pulse_vals[i] !== 4'b1000) begin
        fails++;
        $display("FAIL hold_pulse%0d frame=%0d val=%b exp=%0d/1000", i,
                 (pulse_vals.size() > i) ? pulse_frames[i] : -1,
                 (pulse_vals.size() > i) ? pulse_vals[i] : 4'hx,
                 exp_f[i]);
      end
    end
    do_frames(10, 20);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 5) begin
      fails++;
      $display("FAIL hold_release got=%0d exp=5", pulse_vals.size());
    end
  endtask

  task automatic test_conflict();
    clear_log();
    buttons[1:0] = 2'b11;
    clk_wait(10);
    do_frames(3, 20);
    buttons[1] = 1'b0;
    clk_wait(10);
    do_frames(3, 20);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 0) begin
      fails++;
      $display("FAIL conflict_quiet got=%0d exp=0", pulse_vals.size());
    end
    buttons[0] = 1'b0;
    clk_wait(10);
    buttons[0] = 1'b1;
    clk_wait(10);
    do_frames(1, 20);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 1 || pulse_vals[0] !== 4'b0001) begin
      fails++;
      $display("FAIL conflict_repress n=%0d exp=1x0001",
               pulse_vals.size());
    end
    buttons[0] = 1'b0;
    clk_wait(10);
    do_frames(1, 20);
    clear_log();
    buttons[0] = 1'b1;
    clk_wait(10);
    buttons[1] = 1'b1;
    clk_wait(10);
    do_frames(2, 20);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 0) begin
      fails++;
      $display("FAIL conflict_pending got=%0d exp=0", pulse_vals.size());
    end
    buttons = 4'd0;
    clk_wait(10);
    do_frames(1, 20);
  endtask

  task automatic test_simultaneous();
    clear_log();
    buttons = 4'b0110;
    clk_wait(10);
    buttons = 4'b0000;
    do_frames(1, 20);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 1) begin
      fails++;
      $display("FAIL simul_count got=%0d exp=1", pulse_vals.size());
    end
    tests++;
    if (pulse_vals.size() < 1 || pulse_vals[0] !== 4'b0110) begin
      fails++;
      $display("FAIL simul_value n=%0d exp=0110", pulse_vals.size());
    end
    do_frames(1, 20);
  endtask

  task automatic test_step();
    logic [3:0] sel_v [5] = '{4'd12, 4'd8, 4'd9, 4'd3, 4'd15};
    logic [3:0] exp_v [5] = '{4'd8, 4'd8, 4'd8, 4'd3, 4'd8};
    logic [3:0] prev;
    stepSelect = 4'd0;
    clk_wait(5);
    do_frames(1, 20);
    tests++;
    if (moveStep !== 4'd1) begin
      fails++;
      $display("FAIL step_zero got=%0d exp=1", moveStep);
    end
    prev = 4'd1;
    for (int i = 0; i < 5; i++) begin
      stepSelect = sel_v[i];
      clk_wait(10);
      tests++;
      if (moveStep !== prev) begin
        fails++;
        $display("FAIL step_mid%0d got=%0d exp=%0d", i, moveStep, prev);
      end
      do_frames(1, 20);
      tests++;
      if (moveStep !== exp_v[i]) begin
        fails++;
        $display("FAIL step_tick%0d got=%0d exp=%0d", i, moveStep,
                 exp_v[i]);
      end
      prev = exp_v[i];
    end
  endtask

  task automatic test_reset_mid_repeat();
    clear_log();
    stepSelect = 4'd5;
    buttons[0] = 1'b1;
    clk_wait(10);
    do_frames(37, 20);
    tests++;
    if (moveDirection !== 4'b0001) begin
      fails++;
      $display("FAIL rpt_pulse got=%b exp=0001", moveDirection);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (moveDirection !== 4'd0 || moveStep !== 4'd1) begin
      fails++;
      $display("FAIL reset_async dir=%b step=%0d exp=0000/1",
               moveDirection, moveStep);
    end
    clk_wait(3);
    reset = 1'b0;
    clear_log();
    clk_wait(1);
    tests++;
    if (moveDirection !== 4'd0) begin
      fails++;
      $display("FAIL reset_release got=%b exp=0000", moveDirection);
    end
    do_frames(1, 20);
    clk_wait(2);
    tests++;
    if (pulse_vals.size() != 1 || pulse_vals[0] !== 4'b0001) begin
      fails++;
      $display("FAIL reset_rearm n=%0d exp=1x0001", pulse_vals.size());
    end
    tests++;
    if (moveStep !== 4'd5) begin
      fails++;
      $display("FAIL reset_step got=%0d exp=5", moveStep);
    end
    buttons = 4'd0;
    clk_wait(10);
    do_frames(1, 20);
  endtask

  task automatic test_invariants();
    clk_wait(3);
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL pulse_invariants got=%0d exp=0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_repeat();
    test_conflict();
    test_simultaneous();
    test_step();
    test_reset_mid_repeat();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_command_generator.md
Name: move_command_generator

Overview:
Upstream stage of the offset handler. Conditions four raw push-buttons {Right, Left, Down, Up} and a step-select switch bank into frame-synchronous, single-cycle moveDirection pulses plus a stable moveStep value. Provides tap-to-move, hold-to-auto-repeat and per-axis conflict cancellation, so the drawable region moves at most once per frame per axis, during blanking.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a button level change (10 ms at 50 MHz).
REPEAT_DELAY_FRAMES, 30, frames a button must be held after the first move before auto-repeat begins.
REPEAT_RATE_FRAMES, 6, frames between auto-repeat moves.
MAX_STEP, 8, upper clamp on moveStep.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
buttons  in  4  raw asynchronous buttons; bit order {Right, Left, Down, Up}.
stepSelect  in  4  raw step switches; quasi-static.
frameTick  in  1  one-cycle pulse at vertical-blank start, synchronous to clock.
moveDirection  out  4  one-cycle move pulses, same bit order as buttons.
moveStep  out  4  move size in character units, 1..MAX_STEP.

Behaviour:
- Reset: moveDirection = 0, moveStep = 1, both axis FSMs in IDLE, debounced levels = 0, all counters = 0.
- Input conditioning: each button bit passes through a 2-flop synchroniser. It is then debounced: the accepted level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive clocks. Any bounce restarts the count.
- Press edge: a 0->1 transition of an accepted level. Press edges are one clock wide.
- Axes are independent: vertical = {Down, Up}, horizontal = {Right, Left}.
- Conflict: both buttons of one axis accepted high causes that axis FSM to go to IDLE and emit nothing until both are released.
- Axis FSM states:
  - IDLE: on a press edge of exactly one axis button, latch that direction and go to PENDING.
  - PENDING: on frameTick, emit a pulse for the latched direction, load frameCnt = REPEAT_DELAY_FRAMES, go to HOLD. A release while in PENDING does not cancel; a tap is never lost.
  - HOLD: on each frameTick, decrement frameCnt. When it reaches 0, emit a pulse, load REPEAT_RATE_FRAMES, go to REPEAT. A release goes to IDLE with no pulse.
  - REPEAT: same counting as HOLD, reloading REPEAT_RATE_FRAMES after each pulse. A release goes to IDLE.
- Conflict overrides all states, including PENDING (the latched tap is discarded).
- Pulse timing: moveDirection bit is high for exactly the one clock following the frameTick cycle. No bit is ever high for two consecutive cycles. Both axes may pulse in the same cycle. Up and Down are never high together; Left and Right are never high together.
- moveStep: updated only on the frameTick cycle, so it is stable throughout any pulse. stepSelect is sampled through a 2-flop synchroniser. A value of 0 maps to 1; values above MAX_STEP clamp to MAX_STEP.
- frameCnt is 8 bits wide; the parameters must fit in 8 bits.
- A reset asserted mid-hold clears everything immediately. No pulse is emitted on the reset-release cycle.
- frameTick arriving while in IDLE has no effect except updating moveStep.

Decomposition:
- Shared include: direction bit indices (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), axis FSM state encodings, and default debounce and repeat constants, all alongside the existing global display constants.
- Sub-module button_debouncer (synchroniser + counter + accepted level + press-edge output), instantiated four times.
- Axis FSM written once as a generate/loop body or a local task, used for both axes.

Test Plan:
1. Tap (DEBOUNCE_CYCLES=4 for sim): Up high for 20 clocks with 3 bounce toggles first, frameTick every 100 clocks -> exactly one moveDirection=0001 pulse, 1 clock after the next frameTick; none after.
2. Hold Right for 50 frames, REPEAT_DELAY=30, REPEAT_RATE=6 -> pulses 1000 at frames 1, 31, 37, 43, 49; none after release.
3. Up and Down both held -> moveDirection[1:0] stays 00. Release Down -> no pulse until a new Up press edge.
4. Simultaneous Left and Down press -> single cycle with moveDirection=0110.
5. stepSelect=0 -> moveStep=1; stepSelect=12 -> moveStep=8. Change stepSelect mid-frame -> moveStep changes only on the frameTick cycle.
6. Reset asserted during REPEAT -> outputs 0, moveStep=1 immediately. Button still held after reset -> new debounce, then a first move on the next frameTick.
